// File: rtl/nn_result_drain.sv
// nn_result_drain
//   Snapshots N signed accumulators on one ld pulse. Each one is rescaled to
//   OUT_W bits by an arithmetic right shift followed by narrowing. The rescaled
//   values are then streamed out one element per valid/ready transfer.
//   Optional build macro: NN_DRAIN_SAT_EN
//     defined   -> narrowing saturates to the OUT_W signed range
//     undefined -> narrowing truncates (wraps on overflow)
module nn_result_drain #(
    parameter int N     = 4,
    parameter int IN_W  = 21,
    parameter int OUT_W = 8,
    parameter int SHIFT = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld,
    input  logic [N*IN_W-1:0]      in_vec,
    output logic                   busy,
    output logic [OUT_W-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   done
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // Rescale one accumulator: drop SHIFT fractional bits keeping the sign, then narrow.
    function automatic logic [OUT_W-1:0] f_conv(input logic signed [IN_W-1:0] x);
        logic signed [IN_W-1:0] s;
        logic [OUT_W-1:0]       res;
        s = x >>> SHIFT;
`ifdef NN_DRAIN_SAT_EN
        // The value fits when every bit above the OUT_W sign bit copies the sign.
        if (s[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){s[IN_W-1]}}) begin
            res = s[OUT_W-1:0];
        end else if (s[IN_W-1]) begin
            res = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res = {1'b0, {(OUT_W-1){1'b1}}};
        end
`else
        res = s[OUT_W-1:0];
`endif
        return res;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IN_W-1:0]   r_snap [N];
    logic [OUT_W-1:0]  r_data;
    logic [OUT_W-1:0]  w_data_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [IDX_W-1:0]  w_idx_inc;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_capture;
    logic              w_xfer;

    assign w_idx_inc = r_idx + IDX_W'(1);
    assign w_xfer    = r_valid & out_ready;

    assign busy      = r_busy;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_valid = r_valid;
    assign done      = r_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; holding the current values is the default.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                if (ld) begin
                    // Element 0 is converted straight from the input so it is presented one cycle after capture.
                    w_capture   = 1'b1;
                    w_state_nxt = S_STREAM;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_idx_nxt   = ZERO_IDX;
                    w_data_nxt  = f_conv(in_vec[IN_W-1:0]);
                end else begin
                    w_idx_nxt   = ZERO_IDX;
                end
            end
            S_STREAM: begin
                if (w_xfer) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = ZERO_IDX;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                        w_data_nxt  = f_conv(r_snap[w_idx_inc]);
                    end
                end else begin
                    // Stall: everything presented stays put until the consumer accepts.
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_idx_nxt   = ZERO_IDX;
            end
        endcase
    end

    // Snapshot registers: loaded only on an accepted capture, so later in_vec changes are invisible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                r_snap[k] <= {IN_W{1'b0}};
            end
        end else if (w_capture) begin
            for (int k = 0; k < N; k++) begin
                r_snap[k] <= in_vec[k*IN_W +: IN_W];
            end
        end
    end

    // Registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= {OUT_W{1'b0}};
            r_idx   <= ZERO_IDX;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_data  <= w_data_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_nn_result_drain.sv
// Scoreboard bench for nn_result_drain (N=4, IN_W=21, OUT_W=8, SHIFT=7).
// The driver pushes expected (idx, data) pairs when it issues a capture.
// A negedge monitor checks the handshake outputs and pops entries on transfers.
module tb_nn_result_drain;

    localparam int N     = 4;
    localparam int IN_W  = 21;
    localparam int OUT_W = 8;
    localparam int SHIFT = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ld  = 1'b0;
    logic [N*IN_W-1:0] in_vec = '0;
    logic              busy;
    logic [OUT_W-1:0]  out_data;
    logic [1:0]        out_idx;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              done;

    nn_result_drain #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .in_vec    (in_vec),
        .busy      (busy),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   push_cyc = -10;
    int   rdy_mode = 0;
    int   pcnt     = 0;
    bit   exp_done = 1'b0;

    // Reference rescale: floor division by 2^SHIFT, then clamp or wrap to 8 bits.
    function automatic logic [7:0] ref_conv(input logic [IN_W-1:0] e);
        int x;
        int s;
        int d;
        logic signed [IN_W-1:0] se;
        se = e;
        x  = se;
        d  = 1 << SHIFT;
        if (x >= 0) s = x / d;
        else        s = -((-x + d - 1) / d);
`ifdef NN_DRAIN_SAT_EN
        if (s > 127)       s = 127;
        else if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    function automatic logic [N*IN_W-1:0] rand_vec();
        logic [N*IN_W-1:0] r;
        logic [IN_W-1:0]   e;
        int t;
        r = '0;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 2))
                0:       e = IN_W'($urandom);
                1:       begin t = int'($urandom_range(0, 65535)) - 32768; e = IN_W'(t); end
                default: begin t = int'($urandom_range(0, 2047)) - 1024;   e = IN_W'(t); end
            endcase
            r[k*IN_W +: IN_W] = e;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Cycle counter used to time the capture-to-valid latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Ready generator: always on, 1-0-0 pattern, or random.
    always @(posedge clk) begin
        #1;
        pcnt++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((pcnt % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: checks outputs against the scoreboard and pops on transfers.
    always @(negedge clk) begin
        bit ev;
        if (rst) begin
            check("rst_valid", out_valid, 0);
            check("rst_busy",  busy,      0);
            check("rst_done",  done,      0);
            check("rst_data",  out_data,  0);
            check("rst_idx",   out_idx,   0);
            sb_q.delete();
            exp_done = 1'b0;
        end else begin
            check("done", done, exp_done);
            exp_done = 1'b0;
            ev = (sb_q.size() > 0) && (cyc > push_cyc);
            check("valid", out_valid, ev);
            check("busy",  busy,      ev);
            if (out_valid && sb_q.size() > 0) begin
                check("data", out_data, sb_q[0].data);
                check("idx",  out_idx,  sb_q[0].idx);
                if (out_ready) begin
                    if (sb_q[0].idx == 2'(N - 1)) exp_done = 1'b1;
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a capture and record what the stream must deliver.
    task automatic load(input logic [N*IN_W-1:0] v);
        exp_t e;
        in_vec = v;
        ld     = 1'b1;
        for (int k = 0; k < N; k++) begin
            e.idx  = 2'(k);
            e.data = ref_conv(v[k*IN_W +: IN_W]);
            sb_q.push_back(e);
        end
        push_cyc = cyc;
    endtask

    task automatic wait_size(input int target, input int budget);
        int n;
        n = 0;
        while (sb_q.size() > target && n < budget) begin
            step();
            n++;
        end
        if (sb_q.size() > target) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d entries left, wanted %0d", sb_q.size(), target);
            sb_q.delete();
        end
    endtask

    initial begin
        logic [N*IN_W-1:0] v2;
        logic [N*IN_W-1:0] v4;
        logic [N*IN_W-1:0] v1;
        v2 = {21'h1FFF00, 21'd384, 21'd128, 21'd256};
        v4 = {21'd0, 21'd0, 21'h1F0000, 21'h010000};
        v1 = {21'd0, 21'd0, 21'd0, 21'd128};

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Straight stream, consumer always ready.
        rdy_mode = 0;
        step();
        load(v2); step(); ld = 1'b0;
        wait_size(0, 50);

        // Same load with a stalling consumer.
        rdy_mode = 1;
        step();
        load(v2); step(); ld = 1'b0;
        wait_size(0, 100);

        // Narrowing overflow.
        rdy_mode = 0;
        step();
        load(v4); step(); ld = 1'b0;
        wait_size(0, 50);

        // Reset after two transfers, then a fresh load.
        step();
        load(v2); step(); ld = 1'b0;
        wait_size(2, 50);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step(); step();
        load(v1); step(); ld = 1'b0;
        wait_size(0, 50);

        // ld held high while in_vec changes every cycle; new capture only once idle.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            in_vec = rand_vec();
            ld     = 1'b1;
            if (sb_q.size() == 0) load(in_vec);
            step();
        end
        ld = 1'b0;
        wait_size(0, 200);

        // Random ld pulses with random consumer.
        for (int i = 0; i < 600; i++) begin
            in_vec = rand_vec();
            ld     = ($urandom_range(0, 3) == 0);
            if (ld && sb_q.size() == 0) load(in_vec);
            step();
        end
        ld = 1'b0;
        wait_size(0, 200);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
